kpyd_scan_ctrl: RTL and testbench

KPYD_SCAN_CTRL -- requirements
Module: kpyd_scan_ctrl

---
 rtl/kpyd_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_kpyd_scan_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kpyd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kpyd_scan_ctrl
// Description : 4x4 keypad column scanner with press/release debounce and a
//               one-entry ready/valid key-code output with sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module kpyd_scan_ctrl #(
   parameter int DWELL_CYCLES   = 1200,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [3:0] kpyd_row_i,
   output logic [3:0] kpyd_col_o,
   output logic       key_valid_o,
   output logic [3:0] key_code_o,
   input  logic       key_ready_i,
   output logic       key_held_o,
   output logic       overrun_o
);

   localparam int                 c_DW_W    = $clog2(DWELL_CYCLES);
   localparam logic [c_DW_W-1:0]  c_DW_LAST = c_DW_W'(DWELL_CYCLES - 1);
   localparam logic [3:0]         c_DB      = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      ST_SCAN       = 2'd0,
      ST_PRESS_DB   = 2'd1,
      ST_HELD       = 2'd2,
      ST_RELEASE_DB = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [c_DW_W-1:0]   r_dwell;
   logic [1:0]          r_col_idx, w_col_nxt;
   logic [1:0]          r_cand_row, w_cand_nxt;
   logic [3:0]          r_match, w_match_nxt;
   logic [3:0]          r_release, w_release_nxt;
   logic                r_push, w_push;
   logic [3:0]          r_push_code, w_push_code;
   logic                r_valid;
   logic [3:0]          r_code;
   logic                r_overrun;

   logic                w_sample;
   logic [1:0]          w_low_idx;
   logic                w_cand_low;
   logic [3:0]          w_match_inc;
   logic [3:0]          w_release_inc;

   assign w_sample      = (r_dwell == c_DW_LAST);
   assign w_cand_low    = ~kpyd_row_i[r_cand_row];
   assign w_match_inc   = r_match + 4'd1;
   assign w_release_inc = r_release + 4'd1;

   // Lowest-numbered low row wins when several are pressed together
   always_comb begin
      w_low_idx = 2'd3;
      if (!kpyd_row_i[0])      w_low_idx = 2'd0;
      else if (!kpyd_row_i[1]) w_low_idx = 2'd1;
      else if (!kpyd_row_i[2]) w_low_idx = 2'd2;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_col_nxt     = r_col_idx;
      w_cand_nxt    = r_cand_row;
      w_match_nxt   = r_match;
      w_release_nxt = r_release;
      w_push        = 1'b0;
      w_push_code   = {r_cand_row, r_col_idx};
      if (w_sample) begin
         case (r_state)
            ST_SCAN: begin
               if (kpyd_row_i == 4'b1111) begin
                  w_col_nxt = r_col_idx + 2'd1;
               end else begin
                  w_cand_nxt  = w_low_idx;
                  w_match_nxt = 4'd1;
                  w_push_code = {w_low_idx, r_col_idx};
                  if (c_DB == 4'd1) begin
                     w_push      = 1'b1;
                     w_state_nxt = ST_HELD;
                  end else begin
                     w_state_nxt = ST_PRESS_DB;
                  end
               end
            end
            ST_PRESS_DB: begin
               if (w_cand_low) begin
                  w_match_nxt = w_match_inc;
                  if (w_match_inc == c_DB) begin
                     w_push      = 1'b1;
                     w_state_nxt = ST_HELD;
                  end
               end else begin
                  w_state_nxt = ST_SCAN;
                  w_col_nxt   = r_col_idx + 2'd1;
               end
            end
            ST_HELD: begin
               if (!w_cand_low) begin
                  w_release_nxt = 4'd1;
                  if (c_DB == 4'd1) begin
                     w_state_nxt = ST_SCAN;
                     w_col_nxt   = r_col_idx + 2'd1;
                  end else begin
                     w_state_nxt = ST_RELEASE_DB;
                  end
               end
            end
            ST_RELEASE_DB: begin
               if (!w_cand_low) begin
                  w_release_nxt = w_release_inc;
                  if (w_release_inc == c_DB) begin
                     w_state_nxt = ST_SCAN;
                     w_col_nxt   = r_col_idx + 2'd1;
                  end
               end else begin
                  w_state_nxt = ST_HELD;
               end
            end
            default: w_state_nxt = ST_SCAN;
         endcase
      end
   end

   // A push is registered first, then offered to the output stage one edge later
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state     <= ST_SCAN;
         r_dwell     <= '0;
         r_col_idx   <= 2'd0;
         r_cand_row  <= 2'd0;
         r_match     <= 4'd0;
         r_release   <= 4'd0;
         r_push      <= 1'b0;
         r_push_code <= 4'd0;
         r_valid     <= 1'b0;
         r_code      <= 4'd0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_dwell     <= w_sample ? '0 : r_dwell + 1'b1;
         r_col_idx   <= w_col_nxt;
         r_cand_row  <= w_cand_nxt;
         r_match     <= w_match_nxt;
         r_release   <= w_release_nxt;
         r_push      <= w_push;
         r_push_code <= w_push_code;
         if (r_push) begin
            if (!r_valid || key_ready_i) begin
               r_code  <= r_push_code;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && key_ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign kpyd_col_o  = ~(4'b0001 << r_col_idx);
   assign key_valid_o = r_valid;
   assign key_code_o  = r_code;
   assign key_held_o  = (r_state == ST_HELD) || (r_state == ST_RELEASE_DB);
   assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_kpyd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kpyd_scan_ctrl
// Description : Self-checking bench for kpyd_scan_ctrl with a sample-level
//               reference model of the scanner, debouncer and output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kpyd_scan_ctrl;

   localparam int c_DWELL    = 4;
   localparam int c_DEBOUNCE = 2;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [3:0] kpyd_row_i;
   logic [3:0] kpyd_col_o;
   logic       key_valid_o;
   logic [3:0] key_code_o;
   logic       key_ready_i;
   logic       key_held_o;
   logic       overrun_o;

   int n_checks = 0;
   int n_fail   = 0;

   kpyd_scan_ctrl #(
      .DWELL_CYCLES   (c_DWELL),
      .DEBOUNCE_SCANS (c_DEBOUNCE)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .kpyd_row_i  (kpyd_row_i),
      .kpyd_col_o  (kpyd_col_o),
      .key_valid_o (key_valid_o),
      .key_code_o  (key_code_o),
      .key_ready_i (key_ready_i),
      .key_held_o  (key_held_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: m_t is the cycle position inside the current column dwell,
   // m_row is the tracked key row (-1 when none), m_down the debounced key state
   int         m_t, m_col, m_row, m_cnt;
   bit         m_down, m_pend, m_valid, m_ovr;
   logic [3:0] m_code, m_pcode;

   task automatic model_reset();
      m_t = 0; m_col = 0; m_row = -1; m_cnt = 0;
      m_down = 0; m_pend = 0; m_valid = 0; m_ovr = 0;
      m_code = 4'h0; m_pcode = 4'h0;
   endtask

   function automatic int lowest(input logic [3:0] r);
      for (int i = 0; i < 4; i++) if (!r[i]) return i;
      return -1;
   endfunction

   task automatic model_step();
      bit         smp, np;
      logic [3:0] nc;
      int         rr, cc;
      smp = (m_t == c_DWELL - 1);
      m_t = (m_t + 1) % c_DWELL;
      np  = 0;
      nc  = 4'h0;
      if (smp) begin
         if (!m_down && m_row < 0) begin
            if (kpyd_row_i != 4'hF) begin
               m_row = lowest(kpyd_row_i);
               m_cnt = 1;
            end else begin
               m_col = (m_col + 1) % 4;
            end
         end else if (!m_down) begin
            if (!kpyd_row_i[m_row]) m_cnt++;
            else begin m_row = -1; m_col = (m_col + 1) % 4; end
         end else begin
            if (kpyd_row_i[m_row]) m_cnt++;
            else m_cnt = 0;
            if (m_cnt == c_DEBOUNCE) begin
               m_down = 0; m_row = -1; m_cnt = 0; m_col = (m_col + 1) % 4;
            end
         end
         if (!m_down && m_row >= 0 && m_cnt == c_DEBOUNCE) begin
            rr = m_row; cc = m_col;
            np = 1; nc = 4'(rr * 4 + cc);
            m_down = 1; m_cnt = 0;
         end
      end
      if (m_pend) begin
         if (!m_valid || key_ready_i) begin m_code = m_pcode; m_valid = 1; end
         else m_ovr = 1;
      end else if (m_valid && key_ready_i) begin
         m_valid = 0;
      end
      m_pend  = np;
      m_pcode = nc;
   endtask

   function automatic logic [10:0] m_vec();
      logic [3:0] one;
      int         c;
      one = 4'b0001;
      c   = m_col;
      return {~(one << c), m_valid, m_code, m_down, m_ovr};
   endfunction

   function automatic logic [10:0] dut_vec();
      return {kpyd_col_o, key_valid_o, key_code_o, key_held_o, overrun_o};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      if (reset_i) model_reset();
      else model_step();
      #1;
   endtask

   task automatic wait_col_start(input int c);
      bit found = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (m_col == c && m_t == 0 && m_row < 0 && !m_down) begin found = 1; break; end
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL wait_col_start: column %0d start not reached, col=%b", c, kpyd_col_o);
      end
   endtask

   task automatic test_reset();
      reset_i = 1; kpyd_row_i = 4'hF; key_ready_i = 0;
      #2;
      n_checks++;
      if (dut_vec() !== {4'b1110, 1'b0, 4'h0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL reset_async: got %b expected %b", dut_vec(), {4'b1110, 7'b0});
      end
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (dut_vec() !== {4'b1110, 1'b0, 4'h0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL reset_held: got %b expected %b", dut_vec(), {4'b1110, 7'b0});
      end
      reset_i = 0;
   endtask

   task automatic test_idle_scan();
      logic [3:0] one;
      logic [3:0] exp_col;
      one = 4'b0001;
      for (int k = 1; k <= 20; k++) begin
         tick();
         exp_col = ~(one << ((k / 4) % 4));
         n_checks++;
         if (kpyd_col_o !== exp_col || key_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_rotation: cycle %0d col=%b valid=%b expected col=%b valid=0",
                               k, kpyd_col_o, key_valid_o, exp_col);
         end
         n_checks++;
         if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL idle_model: got %b expected %b", dut_vec(), m_vec());
         end
      end
   endtask

   task automatic test_bounce();
      kpyd_row_i = 4'hF;
      wait_col_start(1);
      tick(); tick(); tick();
      kpyd_row_i = 4'b1011;
      tick();
      kpyd_row_i = 4'hF;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL bounce_model: got %b expected %b", dut_vec(), m_vec());
         end
         if (i == 3) begin
            n_checks++;
            if (kpyd_col_o !== 4'b1011 || key_valid_o !== 1'b0 || key_held_o !== 1'b0) begin
               n_fail++; $display("FAIL bounce_result: col=%b valid=%b held=%b expected col=1011 valid=0 held=0",
                                  kpyd_col_o, key_valid_o, key_held_o);
            end
         end
      end
   endtask

   task automatic test_press();
      int n;
      kpyd_row_i = 4'hF; key_ready_i = 0;
      wait_col_start(1);
      kpyd_row_i = 4'b1011;
      n = 0;
      while (!key_valid_o && n < 40) begin
         tick(); n++;
         n_checks++;
         if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL press_model: got %b expected %b", dut_vec(), m_vec());
         end
      end
      n_checks++;
      if (n != 9) begin
         n_fail++; $display("FAIL press_latency: got %0d cycles expected 9", n);
      end
      n_checks++;
      if (key_code_o !== 4'b1001 || key_held_o !== 1'b1 || kpyd_col_o !== 4'b1101) begin
         n_fail++; $display("FAIL press_result: code=%b held=%b col=%b expected code=1001 held=1 col=1101",
                            key_code_o, key_held_o, kpyd_col_o);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (key_valid_o !== 1'b1 || key_code_o !== 4'b1001 || kpyd_col_o !== 4'b1101) begin
            n_fail++; $display("FAIL press_stable: valid=%b code=%b col=%b expected 1 1001 1101",
                               key_valid_o, key_code_o, kpyd_col_o);
         end
      end
   endtask

   task automatic test_release();
      int n;
      kpyd_row_i = 4'hF;
      n = 0;
      while (key_held_o && n < 40) begin
         tick(); n++;
         n_checks++;
         if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL release_model: got %b expected %b", dut_vec(), m_vec());
         end
      end
      n_checks++;
      if (key_held_o !== 1'b0 || kpyd_col_o !== 4'b1011 || key_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL release_result: held=%b col=%b valid=%b expected held=0 col=1011 valid=1",
                            key_held_o, kpyd_col_o, key_valid_o);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (key_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL valid_hold: got %b expected 1", key_valid_o);
         end
      end
      key_ready_i = 1;
      tick();
      key_ready_i = 0;
      n_checks++;
      if (key_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL accept_clear: valid=%b expected 0", key_valid_o);
      end
   endtask

   task automatic press_until_held(input logic [3:0] rows, input string name);
      int n = 0;
      kpyd_row_i = rows;
      while (!key_held_o && n < 40) begin tick(); n++; end
      n_checks++;
      if (!key_held_o) begin
         n_fail++; $display("FAIL %s: held=%b expected 1", name, key_held_o);
      end
   endtask

   task automatic release_until_idle(input string name);
      int n = 0;
      kpyd_row_i = 4'hF;
      while (key_held_o && n < 40) begin tick(); n++; end
      n_checks++;
      if (key_held_o) begin
         n_fail++; $display("FAIL %s: held=%b expected 0", name, key_held_o);
      end
   endtask

   task automatic test_overrun();
      key_ready_i = 0;
      kpyd_row_i  = 4'hF;
      wait_col_start(3);
      press_until_held(4'b1110, "ovr_press_a");
      tick(); tick();
      release_until_idle("ovr_release_a");
      wait_col_start(2);
      press_until_held(4'b0111, "ovr_press_b");
      tick(); tick();
      n_checks++;
      if (key_code_o !== 4'b0011 || key_valid_o !== 1'b1 || overrun_o !== 1'b1) begin
         n_fail++; $display("FAIL overrun_drop: code=%b valid=%b ovr=%b expected 0011 1 1",
                            key_code_o, key_valid_o, overrun_o);
      end
      release_until_idle("ovr_release_b");
      wait_col_start(2);
      kpyd_row_i = 4'b0111;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (m_pend) break;
      end
      key_ready_i = 1;
      tick();
      key_ready_i = 0;
      n_checks++;
      if (key_code_o !== 4'b1110 || key_valid_o !== 1'b1 || overrun_o !== 1'b1) begin
         n_fail++; $display("FAIL push_on_accept: code=%b valid=%b ovr=%b expected 1110 1 1",
                            key_code_o, key_valid_o, overrun_o);
      end
      n_checks++;
      if (dut_vec() !== m_vec()) begin
         n_fail++; $display("FAIL overrun_model: got %b expected %b", dut_vec(), m_vec());
      end
      release_until_idle("ovr_release_c");
      key_ready_i = 1; tick(); key_ready_i = 0;
   endtask

   task automatic test_async_reset();
      kpyd_row_i = 4'hF;
      wait_col_start(0);
      press_until_held(4'b1101, "areset_press");
      #3;
      reset_i = 1;
      #1;
      n_checks++;
      if (dut_vec() !== {4'b1110, 1'b0, 4'h0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL areset_immediate: got %b expected %b", dut_vec(), {4'b1110, 7'b0});
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (key_valid_o !== 1'b0 || key_held_o !== 1'b0) begin
            n_fail++; $display("FAIL areset_no_push: valid=%b held=%b expected 0 0", key_valid_o, key_held_o);
         end
      end
      reset_i = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL areset_resume: got %b expected %b", dut_vec(), m_vec());
         end
      end
      kpyd_row_i = 4'hF;
   endtask

   task automatic test_random();
      int hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            kpyd_row_i = ($urandom_range(0, 9) < 5) ? 4'hF : 4'($urandom_range(0, 15));
            hold       = $urandom_range(1, 30);
         end
         hold--;
         key_ready_i = ($urandom_range(0, 3) == 0);
         tick();
         n_checks++;
         if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL random_model: cycle %0d got %b expected %b", i, dut_vec(), m_vec());
         end
      end
      key_ready_i = 0;
      kpyd_row_i  = 4'hF;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_idle_scan();
      test_bounce();
      test_press();
      test_release();
      test_overrun();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
